// File: rtl/cpu_types_pkg.sv
// Shared types for the memory request path.
// Provides the word type and the arbiter state encoding.
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic {
      RA_IDLE = 1'b0,
      RA_BUSY = 1'b1
   } ra_state_t;

endpackage

// File: rtl/request_arbiter_if.sv
// Bundle of request_arbiter signals.
// Modport ra faces the arbiter; tb faces the channels and memory.
interface request_arbiter_if #(
   parameter int NCH = 2,
   parameter int CW  = $clog2(NCH)
) (
   input logic CLK
);

   logic              nRST;
   logic [NCH-1:0]    req_ren;
   logic [NCH-1:0]    req_wen;
   logic [NCH*32-1:0] req_addr;
   logic [NCH*32-1:0] req_wdata;
   logic              mem_hit;
   logic [31:0]       mem_rdata;
   logic              mem_ren;
   logic              mem_wen;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [NCH-1:0]    chan_hit;
   logic [31:0]       rdata;
   logic [CW-1:0]     grant_id;
   logic              busy;
   logic              timeout_err;

   modport ra (
      input  CLK, nRST,
      input  req_ren, req_wen,
      input  req_addr, req_wdata,
      input  mem_hit, mem_rdata,
      output mem_ren, mem_wen,
      output mem_addr, mem_wdata,
      output chan_hit, rdata,
      output grant_id, busy,
      output timeout_err
   );

   modport tb (
      input  CLK,
      output nRST,
      output req_ren, req_wen,
      output req_addr, req_wdata,
      output mem_hit, mem_rdata,
      input  mem_ren, mem_wen,
      input  mem_addr, mem_wdata,
      input  chan_hit, rdata,
      input  grant_id, busy,
      input  timeout_err
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending index after i_last.
// Ports: i_pend, i_last in; o_any, o_winner out.
module rr_arbiter #(
   parameter int NCH = 2,
   parameter int CW  = $clog2(NCH)
) (
   input  logic [NCH-1:0] i_pend,
   input  logic [CW-1:0]  i_last,
   output logic           o_any,
   output logic [CW-1:0]  o_winner
);

   // Offsets are walked from farthest to nearest so the
   // nearest pending channel after i_last is assigned last.
   always_comb begin
      o_any    = |i_pend;
      o_winner = '0;
      for (int k = NCH; k >= 1; k--) begin
         for (int i = 0; i < NCH; i++) begin
            if (i == (int'(i_last) + k) % NCH
                && i_pend[i]) begin
               o_winner = CW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/request_arbiter.sv
// Round-robin arbiter of NCH channels onto one memory port
// with a stall watchdog.
// Ports: CLK, nRST; per-channel req_ren/req_wen/req_addr/
// req_wdata; mem_hit/mem_rdata from memory; registered
// mem_ren/mem_wen/mem_addr/mem_wdata; chan_hit pulse and
// rdata to the winner; grant_id, busy, sticky timeout_err.
module request_arbiter
   import cpu_types_pkg::*;
#(
   parameter int NCH      = 2,
   parameter int MAX_WAIT = 255,
   parameter int CW       = $clog2(NCH)
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [NCH-1:0]    req_ren,
   input  logic [NCH-1:0]    req_wen,
   input  logic [NCH*32-1:0] req_addr,
   input  logic [NCH*32-1:0] req_wdata,
   input  logic              mem_hit,
   input  logic [31:0]       mem_rdata,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [NCH-1:0]    chan_hit,
   output logic [31:0]       rdata,
   output logic [CW-1:0]     grant_id,
   output logic              busy,
   output logic              timeout_err
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
   localparam logic [WW-1:0] WAIT_SAT  = {WW{1'b1}};

   ra_state_t     r_state;
   logic          r_ren;
   logic          r_wen;
   word_t         r_addr;
   word_t         r_wdata;
   logic [CW-1:0] r_grant;
   logic [CW-1:0] r_last;
   logic [WW-1:0] r_wait;
   logic          r_to;

   logic [NCH-1:0] w_pend;
   logic           w_any;
   logic [CW-1:0]  w_win;
   logic           w_sel_ren;
   logic           w_sel_wen;
   word_t          w_sel_addr;
   word_t          w_sel_wdata;

   assign w_pend = req_ren | req_wen;

   rr_arbiter #(
      .NCH (NCH),
      .CW  (CW)
   ) u_rr (
      .i_pend   (w_pend),
      .i_last   (r_last),
      .o_any    (w_any),
      .o_winner (w_win)
   );

   // Mux the winning channel's request fields.
   always_comb begin
      w_sel_ren   = 1'b0;
      w_sel_wen   = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      for (int i = 0; i < NCH; i++) begin
         if (i == int'(w_win)) begin
            w_sel_ren   = req_ren[i];
            w_sel_wen   = req_wen[i];
            w_sel_addr  = req_addr[i*32 +: 32];
            w_sel_wdata = req_wdata[i*32 +: 32];
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= RA_IDLE;
         r_ren   <= 1'b0;
         r_wen   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_grant <= '0;
         r_last  <= CW'(NCH - 1);
         r_wait  <= '0;
         r_to    <= 1'b0;
      end else begin
         case (r_state)
            RA_IDLE: begin
               if (w_any) begin
                  // Write wins when both enables are set.
                  r_ren   <= w_sel_ren & ~w_sel_wen;
                  r_wen   <= w_sel_wen;
                  r_addr  <= w_sel_addr;
                  r_wdata <= w_sel_wdata;
                  r_grant <= w_win;
                  r_last  <= w_win;
                  r_wait  <= '0;
                  r_state <= RA_BUSY;
               end
            end
            RA_BUSY: begin
               if (mem_hit) begin
                  r_ren   <= 1'b0;
                  r_wen   <= 1'b0;
                  r_state <= RA_IDLE;
               end else if (r_wait == WAIT_LAST) begin
                  // Abandon without a hit; a channel
                  // still requesting re-arbitrates.
                  r_to    <= 1'b1;
                  r_ren   <= 1'b0;
                  r_wen   <= 1'b0;
                  r_state <= RA_IDLE;
               end else if (r_wait != WAIT_SAT) begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            default: r_state <= RA_IDLE;
         endcase
      end
   end

   // Hit is forwarded in the same cycle, only while BUSY.
   always_comb begin
      chan_hit = '0;
      for (int i = 0; i < NCH; i++) begin
         chan_hit[i] = (r_state == RA_BUSY) && mem_hit
                       && (i == int'(r_grant));
      end
   end

   assign mem_ren     = r_ren;
   assign mem_wen     = r_wen;
   assign mem_addr    = r_addr;
   assign mem_wdata   = r_wdata;
   assign rdata       = mem_rdata;
   assign grant_id    = r_grant;
   assign busy        = (r_state == RA_BUSY);
   assign timeout_err = r_to;

endmodule

// File: tb/tb_request_arbiter.sv
// Directed bench for request_arbiter, NCH=2, MAX_WAIT=4.
// Vector table plus timeout and reset sequences.
module tb_request_arbiter;

   logic clk;

   request_arbiter_if #(.NCH(2)) bus (.CLK(clk));

   request_arbiter #(
      .NCH      (2),
      .MAX_WAIT (4)
   ) dut (
      .CLK         (clk),
      .nRST        (bus.nRST),
      .req_ren     (bus.req_ren),
      .req_wen     (bus.req_wen),
      .req_addr    (bus.req_addr),
      .req_wdata   (bus.req_wdata),
      .mem_hit     (bus.mem_hit),
      .mem_rdata   (bus.mem_rdata),
      .mem_ren     (bus.mem_ren),
      .mem_wen     (bus.mem_wen),
      .mem_addr    (bus.mem_addr),
      .mem_wdata   (bus.mem_wdata),
      .chan_hit    (bus.chan_hit),
      .rdata       (bus.rdata),
      .grant_id    (bus.grant_id),
      .busy        (bus.busy),
      .timeout_err (bus.timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]  ren;
      logic [1:0]  wen;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [31:0] d0;
      logic        hit;
      logic [31:0] rd;
      logic        e_ren;
      logic        e_wen;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [1:0]  e_ch;
      logic        e_gid;
      logic        e_busy;
      logic        e_to;
   } vec_t;

   vec_t tv [20];

   task automatic chk_out(input string p,
                          input logic e_ren,
                          input logic e_wen,
                          input logic [31:0] e_addr,
                          input logic [31:0] e_wdata,
                          input logic [1:0] e_ch,
                          input logic e_gid,
                          input logic e_busy,
                          input logic e_to);
      chk({p, ".mem_ren"}, 32'(bus.mem_ren), 32'(e_ren));
      chk({p, ".mem_wen"}, 32'(bus.mem_wen), 32'(e_wen));
      chk({p, ".mem_addr"}, bus.mem_addr, e_addr);
      chk({p, ".mem_wdata"}, bus.mem_wdata, e_wdata);
      chk({p, ".chan_hit"}, 32'(bus.chan_hit), 32'(e_ch));
      chk({p, ".grant_id"}, 32'(bus.grant_id), 32'(e_gid));
      chk({p, ".busy"}, 32'(bus.busy), 32'(e_busy));
      chk({p, ".timeout"}, 32'(bus.timeout_err), 32'(e_to));
   endtask

   initial begin
      // ch1 read 0x40, hit in 4th BUSY cycle
      tv[0]  = '{2'b10, 2'b00, 32'h0, 32'h40, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0};
      tv[1]  = '{2'b10, 2'b00, 32'h0, 32'h40, 32'h0, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h40, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0};
      tv[2]  = tv[1];
      tv[3]  = tv[1];
      tv[4]  = '{2'b10, 2'b00, 32'h0, 32'h40, 32'h0, 1'b1,
                 32'h12345678,
                 1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b1, 1'b1, 1'b0};
      tv[5]  = '{2'b00, 2'b00, 32'h0, 32'h40, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h40, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0};
      // both channels, hit held high: 0,1,0 rotation
      tv[6]  = '{2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 1'b1, 32'h0,
                 1'b0, 1'b0, 32'h40, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0};
      tv[7]  = '{2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 1'b1, 32'h7,
                 1'b1, 1'b0, 32'h100, 32'h0, 2'b01, 1'b0, 1'b1, 1'b0};
      tv[8]  = '{2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 1'b1, 32'h0,
                 1'b0, 1'b0, 32'h100, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0};
      tv[9]  = '{2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 1'b1, 32'h9,
                 1'b1, 1'b0, 32'h200, 32'h0, 2'b10, 1'b1, 1'b1, 1'b0};
      tv[10] = '{2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 1'b1, 32'h0,
                 1'b0, 1'b0, 32'h200, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0};
      tv[11] = '{2'b11, 2'b00, 32'h100, 32'h200, 32'h0, 1'b1, 32'hb,
                 1'b1, 1'b0, 32'h100, 32'h0, 2'b01, 1'b0, 1'b1, 1'b0};
      tv[12] = '{2'b00, 2'b00, 32'h100, 32'h200, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h100, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0};
      // ch0 ren+wen: write wins; then drops request in BUSY
      tv[13] = '{2'b01, 2'b01, 32'h300, 32'h0, 32'hDEADBEEF, 1'b0,
                 32'h0,
                 1'b0, 1'b0, 32'h100, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0};
      tv[14] = '{2'b01, 2'b01, 32'h300, 32'h0, 32'hDEADBEEF, 1'b0,
                 32'h0,
                 1'b0, 1'b1, 32'h300, 32'hDEADBEEF, 2'b00, 1'b0,
                 1'b1, 1'b0};
      tv[15] = '{2'b00, 2'b00, 32'h999, 32'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b1, 32'h300, 32'hDEADBEEF, 2'b00, 1'b0,
                 1'b1, 1'b0};
      tv[16] = tv[15];
      tv[17] = '{2'b00, 2'b00, 32'h999, 32'h0, 32'h0, 1'b1,
                 32'hCAFEF00D,
                 1'b0, 1'b1, 32'h300, 32'hDEADBEEF, 2'b01, 1'b0,
                 1'b1, 1'b0};
      tv[18] = '{2'b00, 2'b00, 32'h999, 32'h0, 32'h0, 1'b1, 32'h0,
                 1'b0, 1'b0, 32'h300, 32'hDEADBEEF, 2'b00, 1'b0,
                 1'b0, 1'b0};
      tv[19] = '{2'b00, 2'b00, 32'h999, 32'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h300, 32'hDEADBEEF, 2'b00, 1'b0,
                 1'b0, 1'b0};

      bus.nRST      = 1'b0;
      bus.req_ren   = '0;
      bus.req_wen   = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.mem_hit   = 1'b0;
      bus.mem_rdata = '0;

      nxt();
      chk_out("rst", 1'b0, 1'b0, 32'h0, 32'h0,
              2'b00, 1'b0, 1'b0, 1'b0);
      nxt();
      bus.nRST = 1'b1;

      for (int i = 0; i < 20; i++) begin
         bus.req_ren   = tv[i].ren;
         bus.req_wen   = tv[i].wen;
         bus.req_addr  = {tv[i].a1, tv[i].a0};
         bus.req_wdata = {32'h0, tv[i].d0};
         bus.mem_hit   = tv[i].hit;
         bus.mem_rdata = tv[i].rd;
         #1;
         chk_out($sformatf("v%0d", i), tv[i].e_ren,
                 tv[i].e_wen, tv[i].e_addr, tv[i].e_wdata,
                 tv[i].e_ch, tv[i].e_gid, tv[i].e_busy,
                 tv[i].e_to);
         chk($sformatf("v%0d.rdata", i), bus.rdata, tv[i].rd);
         nxt();
      end

      // Watchdog: ch1 read never hit for 4 BUSY cycles.
      bus.req_ren  = 2'b10;
      bus.req_wen  = 2'b00;
      bus.req_addr = {32'h500, 32'h0};
      bus.mem_hit  = 1'b0;
      #1;
      chk("to.idle", 32'(bus.busy), 32'd0);
      nxt();
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("to.c%0d", c),
             {28'h0, bus.busy, bus.mem_ren,
              bus.chan_hit},
             {28'h0, 1'b1, 1'b1, 2'b00});
         chk($sformatf("to.c%0d.err", c),
             32'(bus.timeout_err), 32'd0);
         nxt();
      end
      chk_out("to.fire", 1'b0, 1'b0, 32'h500, 32'h0,
              2'b00, 1'b1, 1'b0, 1'b1);
      nxt();
      chk_out("to.regrant", 1'b1, 1'b0, 32'h500, 32'h0,
              2'b00, 1'b1, 1'b1, 1'b1);
      bus.mem_hit   = 1'b1;
      bus.mem_rdata = 32'hA5A5_0001;
      #1;
      chk("to.hit", 32'(bus.chan_hit), 32'h2);
      chk("to.rdata", bus.rdata, 32'hA5A5_0001);
      nxt();
      bus.mem_hit = 1'b0;
      bus.req_ren = 2'b00;
      #1;
      chk_out("to.done", 1'b0, 1'b0, 32'h500, 32'h0,
              2'b00, 1'b1, 1'b0, 1'b1);
      nxt();

      // Reset asserted in the middle of a BUSY cycle.
      bus.req_ren  = 2'b01;
      bus.req_addr = {32'h0, 32'h600};
      nxt();
      chk("rb.busy", 32'({bus.busy, bus.mem_ren}), 32'h3);
      chk("rb.addr", bus.mem_addr, 32'h600);
      bus.mem_hit = 1'b1;
      #1;
      bus.nRST = 1'b0;
      #1;
      chk_out("rb.async", 1'b0, 1'b0, 32'h0, 32'h0,
              2'b00, 1'b0, 1'b0, 1'b0);
      nxt();
      bus.mem_hit = 1'b0;
      bus.req_ren = 2'b11;
      bus.req_addr = {32'h700, 32'h600};
      bus.nRST = 1'b1;
      nxt();
      chk_out("rb.first", 1'b1, 1'b0, 32'h600, 32'h0,
              2'b00, 1'b0, 1'b1, 1'b0);
      bus.req_ren = 2'b00;
      nxt();

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/request_arbiter.md
# request_arbiter

Parametrised successor to the single-channel request unit. Arbitrates NCH requesting channels (e.g. icache fetch, dcache load/store, snoop writeback) onto one memory request port using round-robin. Latches the winning request and holds the memory enables until `mem_hit`, then pulses a per-channel hit back to the winner. A stall watchdog bounds how long any request may stay outstanding. Sits between the datapath/caches and the memory controller.

## Interface
Parameters:
- `NCH`, 2: number of requesting channels (≥2)
- `MAX_WAIT`, 255: BUSY cycles without `mem_hit` before timeout (≥1)
- `CW`, `$clog2(NCH)`: channel index width (derived, not overridden)

Ports:
- `CLK`  in  1  system clock, rising edge; one clock domain
- `nRST`  in  1  asynchronous, active-low reset
- `req_ren`  in  NCH  per-channel read request, level, held until its `chan_hit`
- `req_wen`  in  NCH  per-channel write request, level, held until its `chan_hit`
- `req_addr`  in  NCH×32  per-channel `word_t` address
- `req_wdata`  in  NCH×32  per-channel `word_t` store data
- `mem_hit`  in  1  memory completion for the current request
- `mem_rdata`  in  32  `word_t` load data, valid with `mem_hit`
- `mem_ren`  out  1  registered memory read enable
- `mem_wen`  out  1  registered memory write enable
- `mem_addr`  out  32  latched address
- `mem_wdata`  out  32  latched store data
- `chan_hit`  out  NCH  one-hot hit pulse to the granted channel
- `rdata`  out  32  `mem_rdata` passthrough, valid with `chan_hit`
- `grant_id`  out  CW  currently/last granted channel
- `busy`  out  1  request outstanding (state BUSY)
- `timeout_err`  out  1  sticky watchdog error

## Operation
- States: IDLE, BUSY.
- IDLE: channel i is pending when `req_ren[i] | req_wen[i]`. If any channel is pending, select the first pending index after `last_grant` (cyclic), then latch op, addr and wdata into registers, set `grant_id`, load `last_grant`, clear `wait_cnt`, and go to BUSY.
- Op select within a channel: if `wen` is set, the op is a write (`mem_wen`=1, `mem_ren`=0). Otherwise the op is a read. `ren` and `wen` are never both driven to memory.
- BUSY: `mem_*` outputs hold their latched values. Input changes on any channel are ignored until return to IDLE, including deassertion by the granted channel.
- BUSY & `mem_hit`: `chan_hit[grant_id]`=1 in the same cycle (combinational from `mem_hit`). Next edge: clear `mem_ren`/`mem_wen` and go to IDLE.
- BUSY & !`mem_hit`: `wait_cnt`++. When `wait_cnt` == MAX_WAIT-1 and there is still no hit: set `timeout_err`, clear enables, go to IDLE, issue no `chan_hit`. The channel will re-arbitrate if it is still requesting.
- `timeout_err` is cleared only by reset.
- `chan_hit` is zero outside BUSY, regardless of `mem_hit`. A stray `mem_hit` in IDLE is ignored.
- `wait_cnt` width is `$clog2(MAX_WAIT+1)` and saturates; it never wraps.

## Timing
- Reset (async assert, sync deassert by source): IDLE, `mem_ren`=`mem_wen`=0, `mem_addr`=`mem_wdata`=0, `grant_id`=0, `last_grant`=NCH-1 (channel 0 wins first), `wait_cnt`=0, `timeout_err`=0, `busy`=0.
- Reset mid-request drops the request immediately, with no `chan_hit`.
- A request present in IDLE at edge N gives `mem_ren`/`mem_wen` high from N+1.
- The minimum hit is at cycle N+1, so `chan_hit` is at N+1. IDLE holds at N+2 and the next grant is enabled from N+3.
- Maximum throughput is one transaction per 2 cycles.
- Fairness: with all channels requesting continuously, grants rotate 0,1,…,NCH-1,0. No channel waits more than NCH-1 transactions.
- Timeout: with no hit, enables drop after exactly MAX_WAIT BUSY cycles, and `timeout_err` rises on that same edge.

## Structure
- `ra_state_t` {RA_IDLE, RA_BUSY} and the `word_t` usage go in `cpu_types_pkg`.
- Interface `request_arbiter_if.vh` provides modports `ra` and `tb`.
- Sub-module `rr_arbiter` (NCH): inputs are the pending vector and `last_grant`; outputs are `any` and `winner` index. It is purely combinational and tested standalone.

## Test plan
- Reset, then ch1 read at addr 0x40 only: `mem_ren`=1, `mem_addr`=0x40 next cycle. `mem_hit` after 3 cycles gives `chan_hit`=2'b10 with `rdata`; enables low on the following edge.
- Both channels request continuously, NCH=2, hit every BUSY cycle: grants alternate 0,1,0,1. `chan_hit` pulses every 2nd cycle.
- ch0 has `ren` and `wen` both set, wdata 0xDEADBEEF: `mem_wen`=1, `mem_ren`=0, `mem_wdata`=0xDEADBEEF.
- MAX_WAIT=4, no `mem_hit`: enables fall after 4 BUSY cycles, `timeout_err`=1 and stays set. No `chan_hit`. The still-requesting channel re-arbitrates and completes on a later hit.
- Granted channel drops its request mid-BUSY, and `mem_hit` arrives in IDLE: outputs hold until the hit. The stray IDLE hit produces no `chan_hit`.
- `nRST` asserted during BUSY: all outputs return to reset values asynchronously, before the next edge.
